// File: rtl/time_counter.sv
// time_counter: 1 Hz prescaler, 24-hour BCD time and debounced minute/hour set buttons.
// Latency: fields update on the tick edge, buttons DEBOUNCE_CYCLES+3 edges after press; no backpressure.
module time_counter_debounce #(
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic btn,
    output logic inc
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_q1  <= btn;
            sync_q2  <= sync_q1;
            stable_q <= stable;
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Only the press edge counts; release is ignored.
    assign inc = stable & ~stable_q;
endmodule

module time_counter #(
    parameter int TICK_DIV        = 27_000_000,
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       run_en,
    input  logic       set_min,
    input  logic       set_hr,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sec_tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          min_inc;
    logic          hr_inc;
    logic          min_carry;
    logic          hr_carry;
    logic          min_step;
    logic          hr_step;

    time_counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .btn     (set_min),
        .inc     (min_inc)
    );

    time_counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hr (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .btn     (set_hr),
        .inc     (hr_inc)
    );

    // A manual minute step swallows a coincident tick carry, including its hour carry.
    always_comb begin
        tick      = run_en && (presc == PRESC_MAX);
        min_carry = tick && (sec_tens == 3'd5) && (sec_ones == 4'd9);
        hr_carry  = min_carry && !min_inc && (min_tens == 3'd5) && (min_ones == 4'd9);
        min_step  = min_inc || min_carry;
        hr_step   = hr_inc || hr_carry;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            sec_tick <= 1'b0;
            sec_tens <= '0;
            sec_ones <= '0;
            min_tens <= '0;
            min_ones <= '0;
            hr_tens  <= '0;
            hr_ones  <= '0;
        end else begin
            sec_tick <= tick;

            if (!run_en || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (!run_en) begin
                sec_tens <= '0;
                sec_ones <= '0;
            end else if (tick) begin
                if (sec_ones == 4'd9) begin
                    sec_ones <= 4'd0;
                    sec_tens <= (sec_tens == 3'd5) ? 3'd0 : sec_tens + 3'd1;
                end else begin
                    sec_ones <= sec_ones + 4'd1;
                end
            end

            if (min_step) begin
                if (min_ones == 4'd9) begin
                    min_ones <= 4'd0;
                    min_tens <= (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;
                end else begin
                    min_ones <= min_ones + 4'd1;
                end
            end

            if (hr_step) begin
                if (hr_tens == 2'd2 && hr_ones == 4'd3) begin
                    hr_tens <= 2'd0;
                    hr_ones <= 4'd0;
                end else if (hr_ones == 4'd9) begin
                    hr_tens <= hr_tens + 2'd1;
                    hr_ones <= 4'd0;
                end else begin
                    hr_ones <= hr_ones + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_time_counter;
    localparam int TD = 4;
    localparam int DC = 3;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run_en  = 1'b0;
    logic       set_min = 1'b0;
    logic       set_hr  = 1'b0;
    logic [1:0] hr_tens;
    logic [3:0] hr_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_tick;

    int checks = 0;
    int errors = 0;

    time_counter #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .run_en   (run_en),
        .set_min  (set_min),
        .set_hr   (set_hr),
        .hr_tens  (hr_tens),
        .hr_ones  (hr_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .sec_tick (sec_tick)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int now_time();
        return (int'(hr_tens) * 10 + int'(hr_ones)) * 10000
             + (int'(min_tens) * 10 + int'(min_ones)) * 100
             + int'(sec_tens) * 10 + int'(sec_ones);
    endfunction

    function automatic logic [19:0] raw_time();
        return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        run_en  = 1'b0;
        set_min = 1'b0;
        set_hr  = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic press(input bit hr);
        if (hr) set_hr = 1'b1;
        else    set_min = 1'b1;
        repeat (10) @(negedge sys_clk);
        set_hr  = 1'b0;
        set_min = 1'b0;
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic press_n(input bit hr, input int n);
        for (int i = 0; i < n; i++) press(hr);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        run_en  = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (raw_time() !== 20'd0 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: time %h tick %b, expected 0 0", raw_time(), sec_tick);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        checks++;
        if (raw_time() !== 20'd0 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: time %h tick %b, expected 0 0", raw_time(), sec_tick);
        end
    endtask

    task automatic test_run();
        int cnt = 0;
        int first = 0;
        int last = 0;
        int bad = 0;
        do_reset();
        run_en = 1'b1;
        for (int i = 1; i <= 240; i++) begin
            @(negedge sys_clk);
            if (sec_tick === 1'b1) begin
                if (cnt == 0) first = i;
                else if (i - last != TD) bad++;
                last = i;
                cnt++;
            end
        end
        checks++;
        if (cnt != 60) begin
            errors++;
            $display("FAIL run_tick_count: got %0d expected 60", cnt);
        end
        checks++;
        if (first != TD) begin
            errors++;
            $display("FAIL run_first_tick: edge %0d expected %0d", first, TD);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL run_tick_spacing: %0d bad gaps expected 0", bad);
        end
        checks++;
        if (now_time() != 100) begin
            errors++;
            $display("FAIL run_time_240: got %0d expected 100", now_time());
        end
        repeat (5) @(negedge sys_clk);
        checks++;
        if (now_time() != 101) begin
            errors++;
            $display("FAIL run_time_245: got %0d expected 101", now_time());
        end
        run_en = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (now_time() != 100) begin
            errors++;
            $display("FAIL run_stop_clear: got %0d expected 100", now_time());
        end
        run_en = 1'b1;
        repeat (TD - 1) @(negedge sys_clk);
        checks++;
        if (now_time() != 100) begin
            errors++;
            $display("FAIL run_restart_early: got %0d expected 100", now_time());
        end
        @(negedge sys_clk);
        checks++;
        if (now_time() != 101 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL run_restart_tick: got %0d tick %b expected 101 1", now_time(), sec_tick);
        end
        run_en = 1'b0;
    endtask

    task automatic test_set();
        do_reset();
        press_n(1'b1, 23);
        press_n(1'b0, 59);
        checks++;
        if (now_time() != 235900) begin
            errors++;
            $display("FAIL set_time: got %0d expected 235900", now_time());
        end
        run_en = 1'b1;
        repeat (4) @(negedge sys_clk);
        checks++;
        if (now_time() != 235901) begin
            errors++;
            $display("FAIL set_run4: got %0d expected 235901", now_time());
        end
        repeat (236) @(negedge sys_clk);
        checks++;
        if (now_time() != 0) begin
            errors++;
            $display("FAIL set_midnight: got %0d expected 0", now_time());
        end
        run_en = 1'b0;
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_min = ((i / 2) % 2 == 0);
            @(negedge sys_clk);
        end
        checks++;
        if (now_time() != 0) begin
            errors++;
            $display("FAIL bounce_reject: got %0d expected 0", now_time());
        end
        set_min = 1'b1;
        repeat (DC + 2) @(negedge sys_clk);
        checks++;
        if (now_time() != 0) begin
            errors++;
            $display("FAIL bounce_early: got %0d expected 0", now_time());
        end
        @(negedge sys_clk);
        checks++;
        if (now_time() != 100) begin
            errors++;
            $display("FAIL bounce_latency: got %0d expected 100", now_time());
        end
        repeat (4) @(negedge sys_clk);
        set_min = 1'b0;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (now_time() != 100) begin
            errors++;
            $display("FAIL bounce_single: got %0d expected 100", now_time());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        press_n(1'b1, 5);
        press_n(1'b0, 59);
        checks++;
        if (now_time() != 55900) begin
            errors++;
            $display("FAIL wrap_setup: got %0d expected 55900", now_time());
        end
        press(1'b0);
        checks++;
        if (now_time() != 50000) begin
            errors++;
            $display("FAIL wrap_min_nocarry: got %0d expected 50000", now_time());
        end
        press_n(1'b1, 18);
        checks++;
        if (now_time() != 230000) begin
            errors++;
            $display("FAIL wrap_hr23: got %0d expected 230000", now_time());
        end
        press(1'b1);
        checks++;
        if (now_time() != 0) begin
            errors++;
            $display("FAIL wrap_hr_zero: got %0d expected 0", now_time());
        end
        set_min = 1'b1;
        set_hr  = 1'b1;
        repeat (10) @(negedge sys_clk);
        set_min = 1'b0;
        set_hr  = 1'b0;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (now_time() != 10100) begin
            errors++;
            $display("FAIL both_buttons: got %0d expected 10100", now_time());
        end
    endtask

    task automatic test_collision();
        do_reset();
        run_en = 1'b1;
        repeat (234) @(negedge sys_clk);
        checks++;
        if (now_time() != 58) begin
            errors++;
            $display("FAIL coll_pre: got %0d expected 58", now_time());
        end
        set_min = 1'b1;
        repeat (5) @(negedge sys_clk);
        checks++;
        if (now_time() != 59 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL coll_59: got %0d tick %b expected 59 0", now_time(), sec_tick);
        end
        @(negedge sys_clk);
        checks++;
        if (now_time() != 100 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL coll_merge: got %0d tick %b expected 100 1", now_time(), sec_tick);
        end
        run_en = 1'b0;
        repeat (5) @(negedge sys_clk);
        set_min = 1'b0;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (now_time() != 100) begin
            errors++;
            $display("FAIL coll_after: got %0d expected 100", now_time());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_en = 1'b1;
        repeat (8) @(negedge sys_clk);
        set_hr = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (now_time() != 2) begin
            errors++;
            $display("FAIL areset_pre: got %0d expected 2", now_time());
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (raw_time() !== 20'd0 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL areset_async: time %h tick %b expected 0 0", raw_time(), sec_tick);
        end
        set_hr = 1'b0;
        @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (TD - 1) @(negedge sys_clk);
        checks++;
        if (now_time() != 0) begin
            errors++;
            $display("FAIL areset_presc: got %0d expected 0", now_time());
        end
        @(negedge sys_clk);
        checks++;
        if (now_time() != 1) begin
            errors++;
            $display("FAIL areset_first_tick: got %0d expected 1", now_time());
        end
        run_en = 1'b0;
        repeat (20) @(negedge sys_clk);
        checks++;
        if (now_time() != 0) begin
            errors++;
            $display("FAIL areset_no_inc: got %0d expected 0", now_time());
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_set();
        test_bounce();
        test_wrap();
        test_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
